// File: rtl/pe_decoder.sv
// Instruction queue + repeat sequencer driving per-lane DSP48 control fields and write-back valid.
// Optional MAX opcode (111) is enabled by defining PE_DECODER_MAX_EN.
module pe_decoder #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DSP    = 4,
  parameter int WB_DELAY   = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inst_v,
  output logic                      inst_ready,
  input  logic [3+REP_WIDTH-1:0]    inst,
  input  logic                      din_ld_v,
  input  logic [2*DATA_WIDTH-1:0]   din_ld,
  input  logic [2*DATA_WIDTH-1:0]   din_wb,
  output logic                      dout_v,
  output logic [2*DATA_WIDTH-1:0]   dout,
  output logic [4*NUM_DSP-1:0]      alumode,
  output logic [5*NUM_DSP-1:0]      inmode,
  output logic [7*NUM_DSP-1:0]      opmode,
  output logic [NUM_DSP-1:0]        cea2,
  output logic [NUM_DSP-1:0]        ceb2,
  output logic [NUM_DSP-1:0]        usemult,
  output logic                      busy
);

  localparam int IW = 3 + REP_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]          PTR_ONE = 1;
  localparam logic [REP_WIDTH-1:0] REP_ONE = 1;

  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_SUB    = 3'b010;
  localparam logic [2:0] OP_MUL    = 3'b100;
  localparam logic [2:0] OP_MULADD = 3'b101;
  localparam logic [2:0] OP_MULSUB = 3'b110;
`ifdef PE_DECODER_MAX_EN
  localparam logic [2:0] OP_MAX    = 3'b111;
`endif

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         fifo_mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  full, empty, push, pop;
  logic                  ready_q;
  logic [2:0]            op_q;
  logic [REP_WIDTH-1:0]  cnt;

  logic [4*NUM_DSP-1:0]  alumode_d;
  logic [5*NUM_DSP-1:0]  inmode_d;
  logic [7*NUM_DSP-1:0]  opmode_d;
  logic [NUM_DSP-1:0]    cea2_d, ceb2_d, usemult_d;
  logic                  token_d, token_q;
  logic [WB_DELAY-1:0]   wb_sr;

  // Full when pointers differ only in the wrap bit
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign inst_ready = ready_q && !full && !rst;
  assign push       = inst_v && inst_ready;
  assign busy       = !empty || (state == ISSUE);
  assign dout_v     = wb_sr[WB_DELAY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      ready_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= inst;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A pop in ISSUE happens on the last repeat so the next op follows without a bubble
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt == '0) begin
          if (!empty) pop = 1'b1;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0;
      cnt  <= '0;
    end else if (pop) begin
      {op_q, cnt} <= fifo_mem[rd_ptr[AW-1:0]];
    end else if (state == ISSUE && cnt != '0) begin
      cnt <= cnt - REP_ONE;
    end
  end

  always_comb begin
    alumode_d = '0;
    inmode_d  = '0;
    opmode_d  = '0;
    cea2_d    = '0;
    ceb2_d    = '0;
    usemult_d = '0;
    token_d   = 1'b0;
    if (state == ISSUE) begin
      for (int i = 0; i < NUM_DSP; i++) begin
        case (op_q)
          OP_ADD, OP_SUB: begin
            alumode_d[4*i +: 4] = (op_q == OP_SUB) ? 4'b0011 : 4'b0000;
            opmode_d[7*i +: 7]  = 7'b0110011;
            cea2_d[i]           = 1'b1;
            ceb2_d[i]           = 1'b1;
          end
          OP_MUL, OP_MULADD, OP_MULSUB: begin
            alumode_d[4*i +: 4] = ((i % 2) == 1 && op_q == OP_MULSUB) ? 4'b0011 : 4'b0000;
            inmode_d[5*i +: 5]  = 5'b10001;
            opmode_d[7*i +: 7]  = ((i % 2) == 1 && op_q != OP_MUL) ? 7'b0110101 : 7'b0000101;
            usemult_d[i]        = 1'b1;
          end
`ifdef PE_DECODER_MAX_EN
          OP_MAX: begin
            alumode_d[4*i +: 4] = 4'b1100;
            opmode_d[7*i +: 7]  = 7'b0110011;
            usemult_d[i]        = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      case (op_q)
        OP_ADD, OP_SUB, OP_MUL, OP_MULADD, OP_MULSUB: token_d = 1'b1;
`ifdef PE_DECODER_MAX_EN
        OP_MAX: token_d = 1'b1;
`endif
        default: token_d = 1'b0;
      endcase
    end
  end

  // token_q is aligned with the control outputs, so dout_v lands WB_DELAY cycles after them
  always_ff @(posedge clk) begin
    if (rst) begin
      alumode <= '0;
      inmode  <= '0;
      opmode  <= '0;
      cea2    <= '0;
      ceb2    <= '0;
      usemult <= '0;
      token_q <= 1'b0;
      wb_sr   <= '0;
    end else begin
      alumode <= alumode_d;
      inmode  <= inmode_d;
      opmode  <= opmode_d;
      cea2    <= cea2_d;
      ceb2    <= ceb2_d;
      usemult <= usemult_d;
      token_q <= token_d;
      wb_sr   <= {wb_sr[WB_DELAY-2:0], token_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           dout <= '0;
    else if (dout_v)   dout <= din_wb;
    else if (din_ld_v) dout <= din_ld;
  end

endmodule
